// File: rtl/noc_inject.sv
// Per-lane NoC ingress transmitter: buffers multiplier results in order, formats
// them as {ctrl, addr, data} words for one merge-tree slot, and tracks batch state.
module noc_inject #(
    parameter int unsigned bit_width    = 16,
    parameter int unsigned log_n_add    = 6,
    parameter int unsigned ctrl_bit     = 1,
    parameter int unsigned log_fifo_len = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [bit_width-1:0]                     in_data,
    input  logic [log_n_add-1:0]                     in_addr,
    input  logic                                     in_last,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic [bit_width+log_n_add+ctrl_bit-1:0]  noc_word,
    input  logic                                     stall,
    output logic                                     done,
    output logic [15:0]                              batch_cnt,
    output logic [15:0]                              stall_cnt
);

    localparam int unsigned DEPTH  = 1 << log_fifo_len;
    localparam int unsigned FDEPTH = DEPTH - 1;
    localparam int unsigned PW     = (log_fifo_len < 1) ? 1 : log_fifo_len;
    localparam int unsigned OW     = log_fifo_len + 1;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [log_n_add-1:0] addr;
        logic [bit_width-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    entry_t             r_mem [FDEPTH];
    entry_t             r_out;
    entry_t             w_in_entry;
    logic               r_out_valid;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic [OW-1:0]      r_occ;
    logic [OW-1:0]      w_occ_nxt;
    logic               r_in_ready;
    logic               r_done;
    logic [CNT_W-1:0]   r_batch_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_ready_nxt;
    logic               w_done_nxt;
    logic               w_accept;
    logic               w_send;
    logic               w_out_free;
    logic               w_fifo_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_load_in;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FDEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Handshake and buffer-steering decisions for this edge
    assign w_in_entry   = '{addr: in_addr, data: in_data};
    assign w_accept     = in_valid && r_in_ready;
    assign w_send       = r_out_valid && !stall;
    assign w_out_free   = !r_out_valid || w_send;
    // The output register is always refilled first, so FIFO words = occ - out_valid
    assign w_fifo_empty = (r_occ == OW'(r_out_valid));
    assign w_pop        = w_out_free && !w_fifo_empty;
    assign w_load_in    = w_accept && w_out_free && w_fifo_empty;
    assign w_push       = w_accept && !w_load_in;

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_accept, w_send})
            2'b10:   w_occ_nxt = r_occ + OW'(1);
            2'b01:   w_occ_nxt = r_occ - OW'(1);
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Batch FSM: next state plus the registered ready/done values
    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_accept && in_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_occ_nxt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
        w_ready_nxt = (w_state_nxt == S_RUN) && (w_occ_nxt < OW'(DEPTH));
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_RUN;
            r_in_ready <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= w_ready_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Occupancy, pointers and output register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_occ       <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_out       <= r_mem[r_rd_ptr];
                r_out_valid <= 1'b1;
            end else if (w_load_in) begin
                r_out       <= w_in_entry;
                r_out_valid <= 1'b1;
            end else if (w_send) begin
                r_out       <= '0;
                r_out_valid <= 1'b0;
            end
        end
    end

    // Storage array carries no reset; occupancy alone defines which entries are live
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_batch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_state == S_DONE) begin
                r_batch_cnt <= '0;
            end else if (w_send) begin
                r_batch_cnt <= r_batch_cnt + CNT_W'(1);
            end
            if (r_out_valid && stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign noc_word  = {ctrl_bit'(r_out_valid), r_out.addr, r_out.data};
    assign in_ready  = r_in_ready;
    assign done      = r_done;
    assign batch_cnt = r_batch_cnt;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_noc_inject.sv
// Self-checking bench for noc_inject: vector table, directed multi-cycle
// sequences, and an in-order scoreboard on every word leaving the block.
module tb_noc_inject;

    localparam int unsigned BW = 16;
    localparam int unsigned AW = 6;
    localparam int unsigned CW = 1;
    localparam int unsigned LF = 2;
    localparam int unsigned WW = BW + AW + CW;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] in_data;
    logic [AW-1:0] in_addr;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] noc_word;
    logic          stall;
    logic          done;
    logic [15:0]   batch_cnt;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    noc_inject #(
        .bit_width   (BW),
        .log_n_add   (AW),
        .ctrl_bit    (CW),
        .log_fifo_len(LF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_addr  (in_addr),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .noc_word (noc_word),
        .stall    (stall),
        .done     (done),
        .batch_cnt(batch_cnt),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [BW-1:0] data;
        logic [AW-1:0] addr;
        logic [WW-1:0] exp_word;
    } vec_t;

    vec_t          tbl [4];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [WW-1:0] sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        sb_q.delete();
        rst = 1'b1;
    endtask

    // Waits for the done pulse, checks batch_cnt, then steps back into RUN
    task automatic wait_done(input string name, input logic [15:0] exp_batch);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_batch"}, 32'(batch_cnt), 32'(exp_batch));
            step();
            check({name, "_done_clr"}, 32'(done), 32'd0);
        end
    endtask

    // Scoreboard: expected word pushed on accept, popped on each send
    always @(negedge clk) begin
        if (rst) begin
            if (noc_word[WW-1] && !stall) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(noc_word), 32'd0);
                end else begin
                    check("sb_order", 32'(noc_word), 32'(sb_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({1'b1, in_addr, in_data});
            end
        end
    end

    initial begin
        int  k;
        int  acc;
        bit  rdy;
        bit  seen;
        logic [WW-1:0] held;

        tbl[0] = '{data: 16'h1234, addr: 6'd5,  exp_word: 23'h451234};
        tbl[1] = '{data: 16'hFFFF, addr: 6'd63, exp_word: 23'h7FFFFF};
        tbl[2] = '{data: 16'h0000, addr: 6'd0,  exp_word: 23'h400000};
        tbl[3] = '{data: 16'hA5A5, addr: 6'd42, exp_word: 23'h6AA5A5};

        rst = 1'b0; in_data = '0; in_addr = '0; in_last = 1'b0; in_valid = 1'b0; stall = 1'b0;
        step();
        step();
        rst = 1'b1;
        check("rst_word",   32'(noc_word),  32'd0);
        check("rst_ready",  32'(in_ready),  32'd1);
        check("rst_done",   32'(done),      32'd0);
        check("rst_batch",  32'(batch_cnt), 32'd0);
        check("rst_stall",  32'(stall_cnt), 32'd0);

        // Single-word batches from the vector table
        for (int i = 0; i < 4; i++) begin
            in_data = tbl[i].data; in_addr = tbl[i].addr; in_last = 1'b1; in_valid = 1'b1;
            check("sw_ready", 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0; in_last = 1'b0;
            check("sw_word",        32'(noc_word), 32'(tbl[i].exp_word));
            check("sw_ready_drain", 32'(in_ready), 32'd0);
            step();
            check("sw_empty", 32'(noc_word),  32'd0);
            check("sw_done",  32'(done),      32'd1);
            check("sw_batch", 32'(batch_cnt), 32'd1);
            step();
            check("sw_done_clr", 32'(done),      32'd0);
            check("sw_ready_run", 32'(in_ready), 32'd1);
            check("sw_batch_clr", 32'(batch_cnt), 32'd0);
        end

        // Back-to-back stream with no bubbles
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = BW'(i); in_addr = AW'(i); in_last = (i == 7);
            check("b2b_ready", 32'(in_ready), 32'd1);
            step();
            check("b2b_word", 32'(noc_word), 32'({1'b1, AW'(i), BW'(i)}));
        end
        in_valid = 1'b0; in_last = 1'b0;
        wait_done("b2b", 16'd8);

        // Backpressure: only DEPTH words fit while the slot is stalled
        stall = 1'b1; k = 0; acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_data = BW'(16'h100 + k); in_addr = AW'(k); in_last = (k == 5);
            rdy = in_ready;
            step();
            if (rdy) begin k++; acc++; end
            check("bp_stable", 32'(noc_word), 32'({1'b1, 6'd0, 16'h0100}));
        end
        check("bp_accepted", 32'(acc),       32'd4);
        check("bp_ready",    32'(in_ready),  32'd0);
        check("bp_stall_cnt", 32'(stall_cnt), 32'd7);
        stall = 1'b0;
        for (int c = 0; c < 20 && k < 6; c++) begin
            in_valid = 1'b1; in_data = BW'(16'h100 + k); in_addr = AW'(k); in_last = (k == 5);
            rdy = in_ready;
            step();
            if (rdy) k++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("bp_all_in", 32'(k), 32'd6);
        wait_done("bp", 16'd6);
        check("bp_stall_hold", 32'(stall_cnt), 32'd7);

        // Batch boundary on word 3 of 5
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = BW'(16'h200 + i); in_addr = AW'(10 + i); in_last = (i == 2);
            check("bb_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_data = 16'h0203; in_addr = 6'd13; in_last = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            check("bb_ready_low", 32'(in_ready), 32'd0);
            if (done) begin
                seen = 1'b1;
                check("bb_batch", 32'(batch_cnt), 32'd3);
            end else begin
                step();
            end
        end
        check("bb_done_seen", 32'(seen), 32'd1);
        step();
        for (int i = 3; i < 5; i++) begin
            in_valid = 1'b1; in_data = BW'(16'h200 + i); in_addr = AW'(10 + i); in_last = (i == 4);
            check("bb_ready_after", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        wait_done("bb2", 16'd2);

        // Reset while three words wait in DRAIN
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = BW'(16'h300 + i); in_addr = AW'(20 + i); in_last = (i == 2);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("rd_in_drain", 32'(in_ready), 32'd0);
        do_reset();
        check("rd_word",  32'(noc_word),  32'd0);
        check("rd_ready", 32'(in_ready),  32'd1);
        check("rd_done",  32'(done),      32'd0);
        check("rd_batch", 32'(batch_cnt), 32'd0);
        check("rd_stall", 32'(stall_cnt), 32'd0);
        stall = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (done || noc_word != '0) seen = 1'b1;
        end
        check("rd_quiet", 32'(seen), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        // Stall counter saturation
        in_valid = 1'b1; in_data = 16'hBEEF; in_addr = 6'd7; in_last = 1'b1; stall = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        held = noc_word;
        check("sat_word", 32'(held), 32'h47BEEF);
        repeat (70000) step();
        check("sat_cnt",    32'(stall_cnt), 32'h0000FFFF);
        check("sat_stable", 32'(noc_word),  32'(held));
        repeat (5) step();
        check("sat_hold",   32'(stall_cnt), 32'h0000FFFF);
        do_reset();
        stall = 1'b0;
        check("sat_rst", 32'(stall_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
